slot_allocator: RTL

Tracks occupancy of a 2**LOG_SLOTS-entry structure (issue queue / ROB-style slot pool) and hands out free slot indices. It keeps a registered busy bit-vector and selects the lowest-index free slot with an internal find-lowest-zero encoder. Downstream structure logic consumes the granted index; completion and commit logic returns indices through the free port.

---
 rtl/slot_allocator_if.sv | 29 ++
 rtl/slot_allocator.sv | 86 ++++++++
 2 files changed

// File: rtl/slot_allocator_if.sv
// Handshake bundle for slot_allocator: allocation request/grant, slot return,
// flush, and the registered occupancy view.
interface slot_allocator_if #(
  parameter int LOG_SLOTS = 3
);
  localparam int NSLOTS = 2 ** LOG_SLOTS;

  logic                 flush;
  logic                 alloc_req;
  logic                 alloc_gnt;
  logic [LOG_SLOTS-1:0] alloc_idx;
  logic                 free_valid;
  logic [LOG_SLOTS-1:0] free_idx;
  logic [NSLOTS-1:0]    busy_vec;
  logic [LOG_SLOTS:0]   count;
  logic                 full;
  logic                 empty;
  logic                 err;

  modport master (
    output flush, alloc_req, free_valid, free_idx,
    input  alloc_gnt, alloc_idx, busy_vec, count, full, empty, err
  );

  modport slave (
    input  flush, alloc_req, free_valid, free_idx,
    output alloc_gnt, alloc_idx, busy_vec, count, full, empty, err
  );
endinterface

// File: rtl/slot_allocator.sv
// Slot pool allocator: busy bit-vector with lowest-free-slot selection.
// Optional sticky protocol-error flag enabled by defining SLOT_ALLOC_ERR_EN.
module slot_allocator #(
  parameter int LOG_SLOTS = 3
) (
  input logic             clk,
  input logic             reset,
  slot_allocator_if.slave bus
);
  localparam int NSLOTS = 2 ** LOG_SLOTS;
  localparam int CW     = LOG_SLOTS + 1;

  logic [NSLOTS-1:0]    busy_q, busy_d;
  logic [CW-1:0]        count_q, count_d;
  logic [LOG_SLOTS-1:0] sel_idx;
  logic                 full;
  logic                 gnt;
  logic                 free_hit;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) sel_idx = LOG_SLOTS'(i);
    end
  end

  assign full     = (count_q == CW'(NSLOTS));
  assign gnt      = bus.alloc_req & ~full & ~bus.flush;
  assign free_hit = bus.free_valid & busy_q[bus.free_idx] & ~bus.flush;

  // A granted slot is idle and a valid free targets a busy slot, so the two
  // updates never touch the same bit.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (bus.flush) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (free_hit) busy_d[bus.free_idx] = 1'b0;
      if (gnt)      busy_d[sel_idx]      = 1'b1;
      count_d = count_q + CW'(gnt) - CW'(free_hit);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

`ifdef SLOT_ALLOC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!bus.flush && ((bus.free_valid && !busy_q[bus.free_idx]) ||
                       (bus.alloc_req && full)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.alloc_gnt = gnt;
  assign bus.alloc_idx = full ? '0 : sel_idx;
  assign bus.busy_vec  = busy_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = (count_q == '0);
endmodule
